bench_core: RTL and testbench
=============================

# bench_core

Parameterised accumulate-and-read datapath block. It initialises an internal accumulator from `data_in` and adds or subtracts further operands. It applies a configurable signedness and overflow policy, and presents a scaled result on a registered output port when output-enable is asserted. It sits behind the sequencing controller as the arithmetic/storage element of the bench datapath.

## Interface
- `DATA_WIDTH`, 8: width of the operand, the accumulator and `data_out`.
- `ATTR_WIDTH`, 4: width of the attribute (output scale) field.
- `SIGN`, 0: 0 = unsigned two's-complement arithmetic; 1 = signed.
- `OVERFLOW`, 1: 1 = saturate on overflow/underflow; 0 = wrap modulo 2^DATA_WIDTH.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `signal_load`  in  1: accepts `data_in` this cycle.
- `signal_init`  in  1: with `signal_load`, replaces the accumulator instead of accumulating.
- `signal_neg`  in  1: negates the operand (subtract / load negative).
- `signal_oe`  in  1: output enable.
- `data_in`  in  DATA_WIDTH: operand.
- `attr_in`  in  ATTR_WIDTH: output right-shift amount, latched on init.
- `data_out`  out  DATA_WIDTH: registered result.

## Operation
- State: `acc` (DATA_WIDTH), `attr_q` (ATTR_WIDTH), `data_out` register.
- load=1, init=1: `acc <= neg ? -data_in : data_in`; `attr_q <= attr_in`.
- load=1, init=0: `acc <= acc + data_in` (neg=0) or `acc - data_in` (neg=1).
- load=0: `acc` holds; `init` and `neg` are ignored.
- Arithmetic is evaluated at DATA_WIDTH+1 bits, then resolved according to `OVERFLOW`.
  - OVERFLOW=1, SIGN=0: clamp to [0, 2^W-1]; unsigned init with neg yields 0 unless data_in=0.
  - OVERFLOW=1, SIGN=1: clamp to [-2^(W-1), 2^(W-1)-1].
  - OVERFLOW=0: truncate to W bits.
- Output value = `acc >> attr_q`: logical shift when SIGN=0, arithmetic shift when SIGN=1. A shift ≥ W gives 0, or sign fill when SIGN=1.
- oe=1: `data_out <= scaled acc`, using the pre-update acc when load is asserted in the same cycle. oe=0: `data_out <= 0`.

## Timing
- Reset (rst_n=0, asynchronous): acc=0, attr_q=0, data_out=0. Release is synchronous to `clk`.
- Load/init latency: acc is updated at the edge that samples load.
- Output latency: 1 cycle from oe to data_out. A value loaded at edge N is visible on data_out after edge N+1, provided oe=1 is sampled at edge N+1.
- No handshake; every asserted load is consumed. Back-to-back loads accumulate every cycle.
- Init held for k cycles re-initialises every cycle (idempotent).
- Reset asserted mid-accumulation discards acc immediately.

## Configuration
- `BENCH_OVF_FLAG_EN` defined: adds output `ovf_flag` (1 bit).
  - Sticky high when any load saturates (OVERFLOW=1) or wraps (OVERFLOW=0).
  - Cleared by init or reset.
- `BENCH_OVF_FLAG_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `bench_pkg`: W-dependent constants (signed/unsigned max/min), and a function computing saturating limits from SIGN.
- Sub-module `bench_sat_addsub` (combinational):
  - Inputs: a, b, sub, SIGN, OVERFLOW.
  - Outputs: result and ovf.
  - Used for both the init-negate and the accumulate paths.
- Top level holds the acc, attr_q and data_out registers, plus the output shifter.

## Test plan
- Reset, then idle with oe=1 -> data_out=0 throughout.
- init(25), load(25), 10 idle cycles, oe for 10 cycles -> data_out=50 one cycle after oe rises; 0 after oe falls.
- init(5) held 2 cycles, load(5), oe -> data_out=10 (re-init does not double-accumulate).
- Saturation, SIGN=0, OVERFLOW=1:
  - init(200), load(100) -> 255.
  - then load with neg=1 (data_in 255), twice -> 0.
- SIGN=1, OVERFLOW=0: init(127), load(1) -> data_out=0x80 (-128); with `BENCH_OVF_FLAG_EN`, ovf_flag=1 until the next init.
- attr_in=2 with init(100), oe -> 25. Assert rst_n low mid-sequence -> data_out=0 asynchronously.

Source files
------------

// File: rtl/bench_pkg.sv
// Shared constants and saturation-limit helpers for the bench accumulate datapath.
// Optional feature macro used by bench_core: BENCH_OVF_FLAG_EN (sticky overflow flag output).
package bench_pkg;

  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] wide_t;

  typedef enum logic {
    ARITH_UNSIGNED = 1'b0,
    ARITH_SIGNED   = 1'b1
  } arith_mode_e;

  typedef struct packed {
    wide_t max_val;
    wide_t min_val;
  } sat_limits_t;

  function automatic wide_t unsigned_max(int w);
    wide_t ones = '1;
    return ones >> (MAX_WIDTH - w);
  endfunction

  function automatic wide_t signed_max(int w);
    wide_t ones = '1;
    return ones >> (MAX_WIDTH - w + 1);
  endfunction

  // Only the low w bits are meaningful: the two's-complement pattern of -2^(w-1).
  function automatic wide_t signed_min(int w);
    wide_t v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

  function automatic sat_limits_t sat_limits(int w, arith_mode_e mode);
    sat_limits_t lim;
    if (mode == ARITH_SIGNED) begin
      lim.max_val = signed_max(w);
      lim.min_val = signed_min(w);
    end else begin
      lim.max_val = unsigned_max(w);
      lim.min_val = '0;
    end
    return lim;
  endfunction

endpackage

// File: rtl/bench_sat_addsub.sv
// Combinational W-bit add/subtract evaluated at W+1 bits, with saturate or wrap
// resolution and an overflow indication.
module bench_sat_addsub
  import bench_pkg::*;
#(
  parameter int W        = 8,
  parameter bit SIGN     = 1'b0,
  parameter bit OVERFLOW = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam sat_limits_t LIM = sat_limits(W, SIGN ? ARITH_SIGNED : ARITH_UNSIGNED);
  localparam logic [W-1:0] MAX_V = LIM.max_val[W-1:0];
  localparam logic [W-1:0] MIN_V = LIM.min_val[W-1:0];

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] sum;
  logic       hit_high;

  // Unsigned: the extra bit is carry/borrow. Signed: the top two bits disagree on overflow.
  always_comb begin
    a_ext    = SIGN ? {a[W-1], a} : {1'b0, a};
    b_ext    = SIGN ? {b[W-1], b} : {1'b0, b};
    sum      = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf      = 1'b0;
    hit_high = 1'b0;
    if (SIGN) begin
      ovf      = sum[W] ^ sum[W-1];
      hit_high = ~sum[W];
    end else begin
      ovf      = sum[W];
      hit_high = ~sub;
    end
    if (ovf && OVERFLOW) begin
      result = hit_high ? MAX_V : MIN_V;
    end else begin
      result = sum[W-1:0];
    end
  end

endmodule

// File: rtl/bench_core.sv
// Accumulate-and-read datapath: init/accumulate with saturate or wrap, scaled registered output.
// Define BENCH_OVF_FLAG_EN to add the sticky ovf_flag output.
module bench_core
  import bench_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ATTR_WIDTH = 4,
  parameter bit SIGN       = 1'b0,
  parameter bit OVERFLOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signal_load,
  input  logic                  signal_init,
  input  logic                  signal_neg,
  input  logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
`ifdef BENCH_OVF_FLAG_EN
  output logic                  ovf_flag,
`endif
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0]          acc;
  logic [ATTR_WIDTH-1:0] attr_q;
  logic [W-1:0]          op_a;
  logic [W-1:0]          next_acc;
  logic                  add_ovf;
  logic [W-1:0]          scaled;

  // Init is computed as 0 +/- data_in so one adder serves both paths.
  assign op_a = signal_init ? '0 : acc;

  bench_sat_addsub #(
    .W        (W),
    .SIGN     (SIGN),
    .OVERFLOW (OVERFLOW)
  ) u_addsub (
    .a      (op_a),
    .b      (data_in),
    .sub    (signal_neg),
    .result (next_acc),
    .ovf    (add_ovf)
  );

  generate
    if (SIGN) begin : g_arith_shift
      logic signed [W-1:0] acc_s;
      assign acc_s  = acc;
      assign scaled = acc_s >>> attr_q;
    end else begin : g_logic_shift
      assign scaled = acc >> attr_q;
    end
  endgenerate

  // data_out samples the pre-update acc, so a same-cycle load shows one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      attr_q   <= '0;
      data_out <= '0;
    end else begin
      if (signal_load) begin
        acc <= next_acc;
        if (signal_init) begin
          attr_q <= attr_in;
        end
      end
      data_out <= signal_oe ? scaled : '0;
    end
  end

`ifdef BENCH_OVF_FLAG_EN
  // Init restarts the sticky flag from its own result rather than OR-ing into history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
    end else if (signal_load) begin
      if (signal_init) begin
        ovf_flag <= add_ovf;
      end else if (add_ovf) begin
        ovf_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = add_ovf;
`endif

endmodule

// File: tb/tb_bench_core.sv
// Directed self-checking bench for bench_core: an unsigned/saturating instance and a
// signed/wrapping instance share one stimulus stream.
module tb_bench_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal_load = 1'b0;
  logic       signal_init = 1'b0;
  logic       signal_neg = 1'b0;
  logic       signal_oe = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [3:0] attr_in = 4'd0;
  logic [7:0] dout_u;
  logic [7:0] dout_s;
`ifdef BENCH_OVF_FLAG_EN
  logic       flag_u;
  logic       flag_s;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bench_core #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .SIGN(1'b0), .OVERFLOW(1'b1)) dut_u (
    .clk(clk), .rst_n(rst_n), .signal_load(signal_load), .signal_init(signal_init),
    .signal_neg(signal_neg), .signal_oe(signal_oe), .data_in(data_in), .attr_in(attr_in),
`ifdef BENCH_OVF_FLAG_EN
    .ovf_flag(flag_u),
`endif
    .data_out(dout_u)
  );

  bench_core #(.DATA_WIDTH(8), .ATTR_WIDTH(4), .SIGN(1'b1), .OVERFLOW(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .signal_load(signal_load), .signal_init(signal_init),
    .signal_neg(signal_neg), .signal_oe(signal_oe), .data_in(data_in), .attr_in(attr_in),
`ifdef BENCH_OVF_FLAG_EN
    .ovf_flag(flag_s),
`endif
    .data_out(dout_s)
  );

  task automatic applyStimulus(input logic load, input logic init, input logic neg,
                               input logic oe, input logic [7:0] data, input logic [3:0] attr);
    signal_load = load;
    signal_init = init;
    signal_neg  = neg;
    signal_oe   = oe;
    data_in     = data;
    attr_in     = attr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_u", dout_u, 8'h00);
    checkOutput("reset_s", dout_s, 8'h00);
`ifdef BENCH_OVF_FLAG_EN
    checkOutput("reset_flag_u", {7'd0, flag_u}, 8'h00);
    checkOutput("reset_flag_s", {7'd0, flag_s}, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with oe high shows zero
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
      checkOutput("idle_oe_u", dout_u, 8'h00);
      checkOutput("idle_oe_s", dout_s, 8'h00);
    end

    // init(25), load(25), 10 idle, oe for 10
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd25, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd25, 4'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    checkOutput("oe_low_u", dout_u, 8'h00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
      checkOutput("acc50_u", dout_u, 8'd50);
      checkOutput("acc50_s", dout_s, 8'd50);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    checkOutput("oe_fall_u", dout_u, 8'h00);
    checkOutput("oe_fall_s", dout_s, 8'h00);

    // init(5) held two cycles, load(5)
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("reinit_u", dout_u, 8'd10);
    checkOutput("reinit_s", dout_s, 8'd10);

    // init(200), load(100): unsigned saturates, signed wraps to -56+100=44
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd200, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd100, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("sat_hi_u", dout_u, 8'd255);
    checkOutput("wrap_s", dout_s, 8'd44);
`ifdef BENCH_OVF_FLAG_EN
    checkOutput("sat_flag_u", {7'd0, flag_u}, 8'h01);
    checkOutput("noovf_flag_s", {7'd0, flag_s}, 8'h00);
`endif

    // Subtract 255 twice; second load overlaps oe so data_out shows pre-update acc
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd255, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'd255, 4'd0);
    checkOutput("sub1_u", dout_u, 8'd0);
    checkOutput("sub1_s", dout_s, 8'd45);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("sat_lo_u", dout_u, 8'd0);
    checkOutput("sub2_s", dout_s, 8'd46);

    // init(127), load(1): signed wraps to 0x80
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd127, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("max_plus1_u", dout_u, 8'h80);
    checkOutput("max_plus1_s", dout_s, 8'h80);
`ifdef BENCH_OVF_FLAG_EN
    checkOutput("wrap_flag_s", {7'd0, flag_s}, 8'h01);
    checkOutput("init_clr_flag_u", {7'd0, flag_u}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    checkOutput("sticky_flag_s", {7'd0, flag_s}, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'd0);
    checkOutput("init_clr_flag_s", {7'd0, flag_s}, 8'h00);
`endif

    // Unsigned init with neg clamps to 0; signed gives -3
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("init_neg_u", dout_u, 8'h00);
    checkOutput("init_neg_s", dout_s, 8'hFD);

    // Shift by 3 and by >= width
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 4'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("shr3_u", dout_u, 8'h10);
    checkOutput("shr3_s", dout_s, 8'hF0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 4'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("shr9_u", dout_u, 8'h00);
    checkOutput("shr9_s", dout_s, 8'hFF);

    // attr 2 with init(100)
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd100, 4'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd10, 4'd0);
    checkOutput("scale_u", dout_u, 8'd25);
    checkOutput("scale_s", dout_s, 8'd25);

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_u", dout_u, 8'h00);
    checkOutput("async_rst_s", dout_s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0);
    checkOutput("post_rst_u", dout_u, 8'h00);
    checkOutput("post_rst_s", dout_s, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
